// File: rtl/picosoc_spi_ctrl.sv
// Memory-mapped SPI master for the PicoSoC iomem bus: programmable SCK divider, CPOL/CPHA modes, NUM_CS chip selects.
// Optional 32-bit word transfers are enabled by defining PICOSOC_SPI_WORD_EN.
module picosoc_spi_ctrl #(
  parameter int          NUM_CS      = 1,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  // state | meaning
  // IDLE  | no transfer; SCK parked at cpol, waiting for a DATA write
  // SETUP | CS asserted, one half-period before the first SCK edge
  // SHIFT | 2N half-periods; an SCK edge opens every half-period but the first is SETUP's exit
  // HOLD  | one half-period after the shift phase, then RX is stored and CS released

`ifdef PICOSOC_SPI_WORD_EN
  localparam int W = 32;
`else
  localparam int W = 8;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_nx;

  logic [15:0]  clkdiv;
  logic         cpol, cpha, cs_keep;
  logic [3:0]   cs_sel;
  logic         word_mode;
  logic [15:0]  div_cnt;
  logic [5:0]   hcnt;
  logic [W-1:0] tx_sh, rx_sh, tx_load;
  logic [31:0]  rx_data, rx_word, ctrl_cur, ctrl_new, rdata_mux;
  logic         rx_valid, rx_overrun, cs_active, sck_q, mosi_q, done_d, ready_q;
  logic         tick, hold_exit, sck_edge, sample, busy;
  logic         is_wr, needs_idle, accept;
  logic         data_start, ctrl_wr, data_rd, ovr_clr;
  logic [1:0]   reg_sel;
  logic [5:0]   hcnt_load;
  logic         unused_bits;

`ifdef PICOSOC_SPI_WORD_EN
  logic word_q;
  assign word_mode = word_q;
  always_comb begin
    tx_load = word_q ? iomem_wdata : {iomem_wdata[7:0], 24'h0};
    rx_word = word_q ? rx_sh : {24'h0, rx_sh[7:0]};
  end
`else
  assign word_mode = 1'b0;
  always_comb begin
    tx_load = iomem_wdata[7:0];
    rx_word = {24'h0, rx_sh};
  end
`endif

  assign reg_sel    = iomem_addr[3:2];
  assign is_wr      = |iomem_wstrb;
  assign tick       = (div_cnt == 16'd0);
  assign hold_exit  = (state == HOLD) && tick;
  assign sck_edge   = ((state == SETUP) && tick) || ((state == SHIFT) && tick && (hcnt != 6'd0));
  // Leading edge leaves the idle level; cpha picks whether that edge samples or shifts.
  assign sample     = (sck_q == cpol) ^ cpha;
  assign busy       = (state != IDLE) || done_d;
  assign hcnt_load  = word_mode ? 6'd63 : 6'd15;

  // Transfer-starting and CTRL writes are only acknowledged once the engine is idle.
  assign needs_idle = ((reg_sel == 2'd1) && iomem_wstrb[0]) || ((reg_sel == 2'd0) && is_wr);
  assign accept     = iomem_valid && !ready_q && (!needs_idle || (state == IDLE) || hold_exit);

  assign data_start = ready_q && is_wr && (reg_sel == 2'd1) && iomem_wstrb[0] && (state == IDLE);
  assign ctrl_wr    = ready_q && is_wr && (reg_sel == 2'd0) && (state == IDLE);
  assign data_rd    = ready_q && !is_wr && (reg_sel == 2'd1);
  assign ovr_clr    = ready_q && is_wr && (reg_sel == 2'd2) && iomem_wstrb[0] && iomem_wdata[2];

  assign ctrl_cur = {4'h0, cs_sel, 4'h0, word_mode, cs_keep, cpha, cpol, clkdiv};
  always_comb begin
    ctrl_new = ctrl_cur;
    for (int b = 0; b < 4; b++)
      if (iomem_wstrb[b]) ctrl_new[8*b +: 8] = iomem_wdata[8*b +: 8];
  end

  always_comb begin
    rdata_mux = 32'h0;
    case (reg_sel)
      2'd0:    rdata_mux = ctrl_cur;
      2'd1:    rdata_mux = hold_exit ? rx_word : rx_data;
      2'd2:    rdata_mux = {29'h0, rx_overrun, rx_valid, busy};
      default: rdata_mux = 32'h0;
    endcase
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = ready_q ? rdata_mux : 32'h0;
  assign spi_sck     = (state == IDLE) ? cpol : sck_q;
  assign spi_mosi    = mosi_q;

  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
    assign spi_cs_n[i] = !(cs_active && (cs_sel == 4'(i)));
  end

  assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata, ctrl_new};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (data_start) state_nx = SETUP;
      SETUP:   if (tick) state_nx = SHIFT;
      SHIFT:   if (tick && (hcnt == 6'd0)) state_nx = HOLD;
      HOLD:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkdiv     <= DEFAULT_DIV;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      cs_keep    <= 1'b0;
      cs_sel     <= 4'h0;
`ifdef PICOSOC_SPI_WORD_EN
      word_q     <= 1'b0;
`endif
      div_cnt    <= 16'h0;
      hcnt       <= 6'h0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data    <= 32'h0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      cs_active  <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      done_d     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= accept;
      done_d  <= hold_exit;

      if (data_start)          div_cnt <= clkdiv;
      else if (state != IDLE)  div_cnt <= tick ? clkdiv : div_cnt - 16'd1;

      if ((state == SETUP) && tick)                          hcnt <= hcnt_load;
      else if ((state == SHIFT) && tick && (hcnt != 6'd0))   hcnt <= hcnt - 6'd1;

      if (data_start) begin
        cs_active <= 1'b1;
        sck_q     <= cpol;
        if (!cpha) begin
          mosi_q <= tx_load[W-1];
          tx_sh  <= {tx_load[W-2:0], 1'b0};
        end else begin
          tx_sh  <= tx_load;
        end
      end else if (sck_edge) begin
        sck_q <= ~sck_q;
        if (sample) begin
          rx_sh <= {rx_sh[W-2:0], spi_miso};
        end else begin
          mosi_q <= tx_sh[W-1];
          tx_sh  <= {tx_sh[W-2:0], 1'b0};
        end
      end

      if (ctrl_wr) begin
        clkdiv  <= ctrl_new[15:0];
        cpol    <= ctrl_new[16];
        cpha    <= ctrl_new[17];
        cs_keep <= ctrl_new[18];
        cs_sel  <= ctrl_new[27:24];
`ifdef PICOSOC_SPI_WORD_EN
        word_q  <= ctrl_new[19];
`endif
        if (!ctrl_new[18] || (ctrl_new[27:24] != cs_sel)) cs_active <= 1'b0;
      end

      // A DATA read landing on the completing cycle consumes the new value.
      if (hold_exit) begin
        rx_data <= rx_word;
        if (!cs_keep) cs_active <= 1'b0;
        if (data_rd) begin
          rx_valid <= 1'b0;
        end else begin
          if (rx_valid) rx_overrun <= 1'b1;
          rx_valid <= 1'b1;
        end
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end

      if (ovr_clr) rx_overrun <= 1'b0;
    end
  end

endmodule
